seg7_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver. It is the next generation of the fixed 4-digit scan logic in our timer top. It adds:
- N digits
- a per-window anode dead-time (anti-ghosting)
- frame-coherent value snapshot
- leading-zero blanking
- per-digit decimal points
- per-digit blink

It sits between any counter/timer core and the board's An/Cat pins.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg7_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: blank pattern, active-low hex font and
// a width helper used by the display blocks.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Bits needed to hold the values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decode.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_FONT[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with anode dead-time,
// frame-coherent snapshot, leading-zero blanking, decimal points and blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_PERIOD = 100_000,
  parameter int BLANK_CYCLES   = 1_000,
  parameter int BLINK_PERIOD   = 25_000_000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    En,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   Dp_Mask,
  input  logic [NUM_DIGITS-1:0]   Blink_Mask,
  input  logic                    Lzb,
  output logic [NUM_DIGITS-1:0]   An,
  output logic [6:0]              Cat_Out,
  output logic                    Dp_Out,
  output logic                    Frame_Tick
);

  localparam int CNT_W = (clog2(REFRESH_PERIOD) < 1) ? 1 : clog2(REFRESH_PERIOD);
  localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = clog2(BLINK_PERIOD);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_PERIOD - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic                    blk_hide_q, blk_hide_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [4*NUM_DIGITS-1:0] snap_val_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_blk_q;
  logic                    snap_lzb_q;
  logic                    snap_ld;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              cat_q, cat_d;
  logic                    dp_q, dp_d;

  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blk, cur_lz;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [6:0]              font_seg;

  // Window counter, digit index and blink phase; all cleared while disabled.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    blk_cnt_d    = blk_cnt_q;
    blk_hide_d   = blk_hide_q;
    frame_tick_d = 1'b0;
    if (!En) begin
      cnt_d      = '0;
      idx_d      = '0;
      blk_cnt_d  = '0;
      blk_hide_d = 1'b0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d        = '0;
          frame_tick_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d  = '0;
        blk_hide_d = ~blk_hide_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  assign snap_ld = En && (cnt_q == '0) && (idx_q == '0);

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above && (snap_val_q[4*i +: 4] == 4'd0);
      lz_blank[i] = (i != 0) && zero_above && snap_lzb_q;
    end
  end

  always_comb begin
    cur_nib = snap_val_q[3:0];
    cur_dp  = snap_dp_q[0];
    cur_blk = snap_blk_q[0];
    cur_lz  = lz_blank[0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = snap_val_q[4*i +: 4];
        cur_dp  = snap_dp_q[i];
        cur_blk = snap_blk_q[i];
        cur_lz  = lz_blank[i];
      end
    end
  end

  hex_to_seg7 u_font (
    .nibble_i (cur_nib),
    .seg_o    (font_seg)
  );

  // Anodes stay driven for blanked or hidden digits so every window has equal on-time.
  always_comb begin
    an_d  = '1;
    cat_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (En && (cnt_q >= CNT_BLANK)) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!(blk_hide_q && cur_blk)) begin
        cat_d = cur_lz ? SEG_BLANK : font_seg;
        dp_d  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      blk_hide_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      snap_blk_q   <= '0;
      snap_lzb_q   <= 1'b0;
      an_q         <= '1;
      cat_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_hide_q   <= blk_hide_d;
      frame_tick_q <= frame_tick_d;
      if (snap_ld) begin
        snap_val_q <= Value;
        snap_dp_q  <= Dp_Mask;
        snap_blk_q <= Blink_Mask;
        snap_lzb_q <= Lzb;
      end
      an_q  <= an_d;
      cat_q <= cat_d;
      dp_q  <= dp_d;
    end
  end

  assign An         = an_q;
  assign Cat_Out    = cat_q;
  assign Dp_Out     = dp_q;
  assign Frame_Tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed steps plus random inputs
// compared each cycle against a time-based reference model.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RP = 8;
  localparam int BC = 2;
  localparam int BP = 64;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        En;
  logic [15:0] Value;
  logic [3:0]  Dp_Mask;
  logic [3:0]  Blink_Mask;
  logic        Lzb;
  logic [3:0]  An;
  logic [6:0]  Cat_Out;
  logic        Dp_Out;
  logic        Frame_Tick;

  int checks = 0;
  int errors = 0;

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference state: t counts enabled cycles since the last enable/reset.
  int          t;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_bl;
  logic        m_lzb;
  logic [3:0]  e_an;
  logic [6:0]  e_cat;
  logic        e_dp, e_ft;

  always #5 Clk = ~Clk;

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_PERIOD (RP),
    .BLANK_CYCLES   (BC),
    .BLINK_PERIOD   (BP)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .En         (En),
    .Value      (Value),
    .Dp_Mask    (Dp_Mask),
    .Blink_Mask (Blink_Mask),
    .Lzb        (Lzb),
    .An         (An),
    .Cat_Out    (Cat_Out),
    .Dp_Out     (Dp_Out),
    .Frame_Tick (Frame_Tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t     = 0;
    m_val = '0;
    m_dp  = '0;
    m_bl  = '0;
    m_lzb = 1'b0;
    e_an  = 4'hF;
    e_cat = 7'h7F;
    e_dp  = 1'b1;
    e_ft  = 1'b0;
  endtask

  // Expected register contents after a rising edge, from the inputs seen at it.
  task automatic model_edge();
    int c;
    int d;
    bit hide;
    if (Rst) begin
      model_reset();
      return;
    end
    e_an  = 4'hF;
    e_cat = 7'h7F;
    e_dp  = 1'b1;
    e_ft  = 1'b0;
    if (!En) begin
      t = 0;
      return;
    end
    c    = t % RP;
    d    = (t / RP) % ND;
    hide = ((t / BP) % 2) == 1;
    if (c == 0 && d == 0) begin
      m_val = Value;
      m_dp  = Dp_Mask;
      m_bl  = Blink_Mask;
      m_lzb = Lzb;
    end
    e_ft = (t % (RP * ND)) == (RP * ND - 1);
    if (c >= BC) begin
      e_an = ~(4'b0001 << d);
      if (!(hide && m_bl[d])) begin
        if (m_lzb && d >= 1 && (m_val >> (4 * d)) == 16'd0)
          e_cat = 7'h7F;
        else
          e_cat = font[m_val[4*d +: 4]];
        e_dp = ~m_dp[d];
      end
    end
    t++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".an"},  {28'd0, An},         {28'd0, e_an});
    check({tag, ".cat"}, {25'd0, Cat_Out},    {25'd0, e_cat});
    check({tag, ".dp"},  {31'd0, Dp_Out},     {31'd0, e_dp});
    check({tag, ".ft"},  {31'd0, Frame_Tick}, {31'd0, e_ft});
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Advance until the next processed state is digit d, window count c.
  task automatic run_until(input int d, input int c, input string tag);
    for (int i = 0; i < 200 && !(((t / RP) % ND) == d && (t % RP) == c); i++) cycle(tag);
  endtask

  initial begin
    Rst        = 1'b1;
    En         = 1'b0;
    Value      = 16'h0000;
    Dp_Mask    = 4'b0000;
    Blink_Mask = 4'b0000;
    Lzb        = 1'b0;
    model_reset();
    #2;
    check_outputs("reset_async");
    run(3, "reset_hold");

    // Basic scan of 1234
    Rst   = 1'b0;
    En    = 1'b1;
    Value = 16'h1234;
    run(40, "scan");

    // Snapshot coherence: new value arrives mid-frame
    run_until(2, 3, "scan");
    Value = 16'hABCD;
    run(48, "snapshot");

    // Leading-zero blanking
    Lzb   = 1'b1;
    Value = 16'h0040;
    run(64, "lzb40");
    Value = 16'h0000;
    run(64, "lzb0");

    // Blink on digit 0, decimal point on digit 1
    Lzb        = 1'b0;
    Value      = 16'h1234;
    Blink_Mask = 4'b0001;
    Dp_Mask    = 4'b0010;
    run(160, "blink_dp");

    // Drop enable during digit 2, then resume
    run_until(2, 4, "blink_dp");
    En = 1'b0;
    run(5, "en_off");
    En = 1'b1;
    run(24, "en_on");

    // Random inputs, including leading zeros and occasional enable drops
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        Value = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      if ($urandom_range(0, 15) == 0) Dp_Mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) Blink_Mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) Lzb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) En = ~En;
      cycle("random");
    end

    // Asynchronous reset in the middle of a lit window
    En = 1'b1;
    run_until(1, 4, "pre_rst");
    #3;
    Rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_mid");
    run(2, "rst_mid_hold");
    Rst = 1'b0;
    run(40, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
